// File: rtl/bcd_pkg.sv
// Shared FSM state, digit type and limits for the BCD accumulator.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, ADJ, DONE} state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   function automatic logic is_legal_digit(input bcd_digit_t d);
      return (d <= BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One decimal digit of addition with carry: digit + addend + carry_in,
// folded back into 0..9 with a carry out.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  bcd_digit_t digit,
   input  bcd_digit_t addend,
   input  logic       carry_in,
   output bcd_digit_t digit_out,
   output logic       carry_out
);

   logic [4:0] t;

   // Five bits are needed since the worst case is 9 + 9 + 1 = 19.
   always_comb begin
      t = {1'b0, digit} + {1'b0, addend} + {4'b0000, carry_in};
      if (t > 5'd9) begin
         digit_out = 4'(t - 5'd10);
         carry_out = 1'b1;
      end else begin
         digit_out = t[3:0];
         carry_out = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_accumulator.sv
// Serial BCD accumulator: adds one digit per accept, one total digit per cycle.
// Define BCD_ACC_SATURATE_EN to clamp to all-nines on overflow instead of wrapping.
module bcd_accumulator
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_digit,
   output logic [4*DIGITS-1:0]   sum_digits,
   output logic                  overflow,
   output logic                  done,
   output logic                  err
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   bcd_digit_t       addend;

   bcd_digit_t       cur_digit;
   bcd_digit_t       cur_addend;
   bcd_digit_t       new_digit;
   logic             new_carry;

   // The single adjust unit walks across the total, least significant digit first.
   assign cur_digit  = sum_digits[{idx, 2'b00} +: 4];
   assign cur_addend = (idx == '0) ? addend : 4'd0;

   bcd_digit_adjust adjust (
      .digit     (cur_digit),
      .addend    (cur_addend),
      .carry_in  (carry),
      .digit_out (new_digit),
      .carry_out (new_carry)
   );

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state      <= IDLE;
         idx        <= '0;
         carry      <= 1'b0;
         addend     <= '0;
         sum_digits <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clear) begin
                  sum_digits <= '0;
                  overflow   <= 1'b0;
               end else if (in_valid) begin
                  if (is_legal_digit(in_digit)) begin
                     addend   <= in_digit;
                     idx      <= '0;
                     carry    <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= ADJ;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ADJ: begin
               sum_digits[{idx, 2'b00} +: 4] <= new_digit;
               carry <= new_carry;
               if (idx == LAST_IDX) begin
                  state <= DONE;
                  done  <= 1'b1;
                  if (new_carry) begin
                     overflow <= 1'b1;
`ifdef BCD_ACC_SATURATE_EN
                     sum_digits <= {DIGITS{BCD_MAX_DIGIT}};
`else
                     sum_digits[{idx, 2'b00} +: 4] <= new_digit;
`endif
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Scoreboard bench for bcd_accumulator: a 2-digit instance for handshake and
// arithmetic cases, plus a 4-digit instance for long accumulation.
module tb_bcd_accumulator;

   logic        CLOCK_50;
   logic        RESET;

   logic        clear, in_valid, in_ready, overflow, done, err;
   logic [3:0]  in_digit;
   logic [7:0]  sum_digits;

   logic        clear4, in_valid4, in_ready4, overflow4, done4, err4;
   logic [3:0]  in_digit4;
   logic [15:0] sum_digits4;

   int          n_checks = 0;
   int          n_bad = 0;

   int          model_total = 0;
   logic        model_ovf = 1'b0;

   typedef struct {
      logic [15:0] sum;
      logic        ovf;
   } exp_t;

   exp_t sb[$];

   bcd_accumulator #(.DIGITS(2)) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_digit   (in_digit),
      .sum_digits (sum_digits),
      .overflow   (overflow),
      .done       (done),
      .err        (err)
   );

   bcd_accumulator #(.DIGITS(4)) dut4 (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .clear      (clear4),
      .in_valid   (in_valid4),
      .in_ready   (in_ready4),
      .in_digit   (in_digit4),
      .sum_digits (sum_digits4),
      .overflow   (overflow4),
      .done       (done4),
      .err        (err4)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] toBcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Integer reference: add, then wrap or clamp at 10^nd.
   function automatic void modelAdd(inout int tot, inout logic ovf, input int d, input int nd);
      int lim;
      lim = 10 ** nd;
      tot = tot + d;
      if (tot >= lim) begin
         ovf = 1'b1;
`ifdef BCD_ACC_SATURATE_EN
         tot = lim - 1;
`else
         tot = tot - lim;
`endif
      end
   endfunction

   always @(negedge CLOCK_50) begin
      if (!RESET && done) begin
         checkOutput("sb_depth", sb.size(), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sum_at_done", {24'd0, sum_digits}, {16'd0, e.sum});
            checkOutput("ovf_at_done", overflow, e.ovf);
         end
      end
   end

   // Called at a negedge with the 2-digit DUT idle; noise keeps poking inputs during ADJ.
   task automatic applyStimulus(input logic [3:0] digit, input logic clr, input logic noise);
      int n;
      exp_t e;
      checkOutput("ready_idle", in_ready, 1);
      clear    = clr;
      in_valid = 1'b1;
      in_digit = digit;
      @(posedge CLOCK_50);
      if (clr) begin
         model_total = 0;
         model_ovf   = 1'b0;
      end else if (digit <= 4'd9) begin
         modelAdd(model_total, model_ovf, int'(digit), 2);
         e.sum = toBcd(model_total) & 16'h00ff;
         e.ovf = model_ovf;
         sb.push_back(e);
      end
      @(negedge CLOCK_50);
      if (noise) begin
         clear    = 1'b1;
         in_digit = 4'd4;
      end else begin
         clear    = 1'b0;
         in_valid = 1'b0;
      end
      if (clr || digit > 4'd9) begin
         checkOutput(clr ? "clear_err" : "illegal_err", err, !clr);
         checkOutput("consume_ready", in_ready, 1);
         checkOutput("consume_sum", {24'd0, sum_digits}, {16'd0, toBcd(model_total)} & 32'hff);
         checkOutput("consume_ovf", overflow, model_ovf);
         for (int k = 0; k < 4; k++) begin
            checkOutput("no_done", done, 0);
            @(negedge CLOCK_50);
         end
      end else begin
         n = 1;
         while (!done && n < 10) begin
            checkOutput("ready_busy", in_ready, 0);
            @(negedge CLOCK_50);
            n++;
         end
         checkOutput("done_latency", n, 3);
         checkOutput("ready_in_done", in_ready, 0);
         clear    = 1'b0;
         in_valid = 1'b0;
         @(negedge CLOCK_50);
         checkOutput("done_one_cycle", done, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      RESET = 1'b1;
      clear = 1'b0; in_valid = 1'b0; in_digit = 4'd0;
      clear4 = 1'b0; in_valid4 = 1'b0; in_digit4 = 4'd0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      RESET = 1'b0;
      @(negedge CLOCK_50);
      checkOutput("rst_sum", sum_digits, 0);
      checkOutput("rst_ovf", overflow, 0);
      checkOutput("rst_ready", in_ready, 1);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);

      // 7 + 5 = 12, second add with inputs toggling during ADJ
      applyStimulus(4'd7, 1'b0, 1'b0);
      applyStimulus(4'd5, 1'b0, 1'b1);
      checkOutput("basic_sum", sum_digits, 8'h12);

      applyStimulus(4'hC, 1'b0, 1'b0);
      applyStimulus(4'hA, 1'b0, 1'b0);

      // Preload 95, then add 8 for the overflow case
      applyStimulus(4'd0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(4'd9, 1'b0, 1'b0);
      applyStimulus(4'd5, 1'b0, 1'b0);
      checkOutput("preload_sum", sum_digits, 8'h95);
      applyStimulus(4'd8, 1'b0, 1'b0);
`ifdef BCD_ACC_SATURATE_EN
      checkOutput("ovf_sum", sum_digits, 8'h99);
`else
      checkOutput("ovf_sum", sum_digits, 8'h03);
`endif
      checkOutput("ovf_flag", overflow, 1);

      // Clear with a concurrent valid digit
      applyStimulus(4'd3, 1'b1, 1'b0);
      checkOutput("clear_sum", sum_digits, 0);
      checkOutput("clear_ovf", overflow, 0);

      for (int i = 0; i < 12; i++) applyStimulus(4'($urandom_range(0, 9)), 1'b0, 1'b0);
      applyStimulus(4'hF, 1'b0, 1'b0);

      // Reset in the middle of ADJ
      applyStimulus(4'd0, 1'b1, 1'b0);
      applyStimulus(4'd4, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_digit = 4'd6;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      in_valid = 1'b0;
      checkOutput("pre_rst_busy", in_ready, 0);
      RESET = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      RESET = 1'b0;
      model_total = 0;
      model_ovf   = 1'b0;
      checkOutput("midrst_ready", in_ready, 1);
      checkOutput("midrst_sum", sum_digits, 0);
      checkOutput("midrst_ovf", overflow, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLOCK_50);
         checkOutput("midrst_no_done", done, 0);
      end

      // Wide instance: 9 added 1112 times
      begin
         int   tot4;
         logic ovf4m;
         tot4  = 0;
         ovf4m = 1'b0;
         for (int i = 0; i < 1112; i++) begin
            in_valid4 = 1'b1;
            in_digit4 = 4'd9;
            @(posedge CLOCK_50);
            modelAdd(tot4, ovf4m, 9, 4);
            @(negedge CLOCK_50);
            in_valid4 = 1'b0;
            n = 1;
            while (!done4 && n < 20) begin
               @(negedge CLOCK_50);
               n++;
            end
            if (n != 5) begin
               checkOutput("wide_latency", n, 5);
               break;
            end
            @(negedge CLOCK_50);
         end
         checkOutput("wide_sum", sum_digits4, toBcd(tot4));
         checkOutput("wide_ovf", overflow4, ovf4m);
`ifdef BCD_ACC_SATURATE_EN
         checkOutput("wide_sum_const", sum_digits4, 16'h9999);
`else
         checkOutput("wide_sum_const", sum_digits4, 16'h0008);
`endif
      end

      checkOutput("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
